// File: rtl/req_encoder_32_pkg.sv
// Shared widths, state encoding and the 5-to-32 one-hot decoder
// used by the request-encoder and register-file blocks.
package req_encoder_32_pkg;

  localparam int VEC_W = 32;
  localparam int IDX_W = 5;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  function automatic logic [VEC_W-1:0] dec_5to32(
    input logic [IDX_W-1:0] idx
  );
    logic [VEC_W-1:0] one;
    one = {{(VEC_W-1){1'b0}}, 1'b1};
    return one << idx;
  endfunction

endpackage

// File: rtl/req_encoder_32_if.sv
// Request-vector in / index-stream out handshake bundle.
interface req_encoder_32_if;
  import req_encoder_32_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [VEC_W-1:0] in_vector;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_index;
  logic             out_last;
  logic             busy;

  modport master (
    output in_valid, in_vector, out_ready,
    input  in_ready, out_valid, out_index, out_last, busy
  );

  modport slave (
    input  in_valid, in_vector, out_ready,
    output in_ready, out_valid, out_index, out_last, busy
  );

endinterface

// File: rtl/req_encoder_32_prio_enc_32.sv
// 32-to-5 priority encoder; the inverse of dec_5to32.
module prio_enc_32
  import req_encoder_32_pkg::*;
(
  input  logic [VEC_W-1:0] vec,
  input  logic             msb_first,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin
    idx = '0;
    any = |vec;
    // Last match in scan order wins, so scan away from the preferred end.
    if (msb_first) begin
      for (int i = 0; i < VEC_W; i++)
        if (vec[i]) idx = IDX_W'(i);
    end else begin
      for (int i = VEC_W - 1; i >= 0; i--)
        if (vec[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/req_encoder_32.sv
// Latches a 32-bit request vector and streams out the index of
// every set bit, one per handshake, lowest- or highest-first.
module req_encoder_32
  import req_encoder_32_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic           clock,
  input  logic           ctrl_reset,
  req_encoder_32_if.slave bus
);

  state_t           state, state_n;
  logic [VEC_W-1:0] pending, pending_n;
  logic [IDX_W-1:0] sel;
  logic             any;
  logic             single;
  logic             drain;

  prio_enc_32 u_prio (
    .vec       (pending),
    .msb_first (MSB_FIRST),
    .idx       (sel),
    .any       (any)
  );

  assign drain  = (state == DRAIN);
  assign single = any && ((pending & (pending - 1'b1)) == '0);

  assign bus.in_ready  = (state == IDLE);
  assign bus.busy      = drain;
  assign bus.out_valid = drain && any;
  assign bus.out_index = drain ? sel : '0;
  assign bus.out_last  = drain && single;

  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      state   <= IDLE;
      pending <= '0;
    end else begin
      state   <= state_n;
      pending <= pending_n;
    end
  end

  always_comb begin
    state_n   = state;
    pending_n = pending;
    unique case (state)
      IDLE: begin
        if (bus.in_valid) begin
          pending_n = bus.in_vector;
          if (|bus.in_vector) state_n = DRAIN;
        end
      end
      DRAIN: begin
        if (bus.out_valid && bus.out_ready) begin
          pending_n = pending & ~dec_5to32(sel);
          if (bus.out_last) state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
